// File: rtl/iterative_tree_reducer.sv
// Captures a SIDE x SIDE pixel frame into a register grid and folds it into grid[0][0]
// one 2x2 level per clock, then presents the sum on a valid/ready output.
module iterative_tree_reducer #(
  parameter int SIDE     = 8,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = DATA_W + 2 * $clog2(SIDE),
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pix_mult_in    [SIDE][SIDE],
  input  logic [DATA_W-1:0] pix_shadowA_in [SIDE][SIDE],
  input  logic [DATA_W-1:0] pix_shadowB_in [SIDE][SIDE],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum_out,
  output logic [1:0]        out_mode,
  output logic              overflow,
  output logic              busy
);

  localparam int LEVELS = $clog2(SIDE);
  localparam int LVL_W  = $clog2(LEVELS + 1);
  localparam int HALF   = SIDE / 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   grid_q [SIDE][SIDE];
  logic [ACC_W-1:0]   grid_d [SIDE][SIDE];
  logic [LVL_W-1:0]   level_q, level_d;
  logic [1:0]         mode_q, mode_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [ACC_W:0]     quad_sum;
  int                 lim;

  function automatic logic [ACC_W-1:0] zext(input logic [DATA_W-1:0] p);
    logic [ACC_W-1:0] r;
    r = '0;
    r[DATA_W-1:0] = p;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Returns {overflowed, stored value}; the raw sum carries two guard bits.
  function automatic logic [ACC_W:0] add4(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                          input logic [ACC_W-1:0] c, input logic [ACC_W-1:0] d);
    logic [ACC_W+1:0] s;
    logic [ACC_W-1:0] v;
    logic             o;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    o = (s[ACC_W+1:ACC_W] != 2'b00);
    if (o && SATURATE) begin
      v = '1;
    end else begin
      v = s[ACC_W-1:0];
    end
    return {o, v};
  endfunction

  // Next-state, grid load and per-level fold.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    mode_d   = mode_q;
    ovf_d    = ovf_q;
    grid_d   = grid_q;
    quad_sum = '0;
    lim      = 0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int x = 0; x < SIDE; x++) begin
            for (int y = 0; y < SIDE; y++) begin
              case (mode)
                2'd0:    grid_d[x][y] = zext(pix_mult_in[x][y]);
                2'd1:    grid_d[x][y] = zext(pix_shadowA_in[x][y]);
                2'd2:    grid_d[x][y] = zext(pix_shadowB_in[x][y]);
                default: grid_d[x][y] = zext(abs_diff(pix_shadowA_in[x][y], pix_shadowB_in[x][y]));
              endcase
            end
          end
          mode_d  = mode;
          level_d = '0;
          ovf_d   = 1'b0;
          state_d = S_REDUCE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDUCE: begin
        lim = SIDE >> (int'(level_q) + 1);
        for (int x = 0; x < HALF; x++) begin
          for (int y = 0; y < HALF; y++) begin
            if ((x < lim) && (y < lim)) begin
              quad_sum = add4(grid_q[2*x][2*y], grid_q[2*x+1][2*y],
                              grid_q[2*x][2*y+1], grid_q[2*x+1][2*y+1]);
              grid_d[x][y] = quad_sum[ACC_W-1:0];
              ovf_d        = ovf_d | quad_sum[ACC_W];
            end else begin
              grid_d[x][y] = grid_q[x][y];
            end
          end
        end
        level_d = level_q + LVL_W'(1);
        if (level_q == LVL_W'(LEVELS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_REDUCE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, grid and handshake flags; flags follow the next state so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      mode_q      <= 2'b00;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int x = 0; x < SIDE; x++) begin
        for (int y = 0; y < SIDE; y++) begin
          grid_q[x][y] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
      grid_q      <= grid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum_out   = grid_q[0][0];
  assign out_mode  = mode_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_iterative_tree_reducer.sv
// Directed bench: four reducer instances (4x4 wide acc, 4x4 8-bit saturating, 4x4 8-bit wrapping,
// 8x8) with hand-computed expected sums, latencies and handshake behaviour.
module tb_iterative_tree_reducer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: SIDE=4, DATA_W=8, ACC_W=12, saturating
  logic       a_valid, a_ready, a_ovalid, a_oready, a_ovf, a_busy;
  logic [1:0] a_mode, a_omode;
  logic [11:0] a_sum;
  logic [7:0] a_mult [4][4];
  logic [7:0] a_shA  [4][4];
  logic [7:0] a_shB  [4][4];

  // Instances B (saturate) and C (wrap): SIDE=4, DATA_W=8, ACC_W=8, shared inputs
  logic       bc_valid, bc_oready;
  logic [1:0] bc_mode;
  logic [7:0] bc_mult [4][4];
  logic [7:0] bc_sh   [4][4];
  logic       b_ready, b_ovalid, b_ovf, b_busy, c_ready, c_ovalid, c_ovf, c_busy;
  logic [1:0] b_omode, c_omode;
  logic [7:0] b_sum, c_sum;

  // Instance D: SIDE=8, DATA_W=8, ACC_W=14
  logic       d_valid, d_ready, d_ovalid, d_oready, d_ovf, d_busy;
  logic [1:0] d_mode, d_omode;
  logic [13:0] d_sum;
  logic [7:0] d_mult [8][8];
  logic [7:0] d_sh   [8][8];

  iterative_tree_reducer #(.SIDE(4), .DATA_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .mode(a_mode),
    .pix_mult_in(a_mult), .pix_shadowA_in(a_shA), .pix_shadowB_in(a_shB),
    .out_valid(a_ovalid), .out_ready(a_oready), .sum_out(a_sum), .out_mode(a_omode),
    .overflow(a_ovf), .busy(a_busy));

  iterative_tree_reducer #(.SIDE(4), .DATA_W(8), .ACC_W(8), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(bc_valid), .in_ready(b_ready), .mode(bc_mode),
    .pix_mult_in(bc_mult), .pix_shadowA_in(bc_sh), .pix_shadowB_in(bc_sh),
    .out_valid(b_ovalid), .out_ready(bc_oready), .sum_out(b_sum), .out_mode(b_omode),
    .overflow(b_ovf), .busy(b_busy));

  iterative_tree_reducer #(.SIDE(4), .DATA_W(8), .ACC_W(8), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(bc_valid), .in_ready(c_ready), .mode(bc_mode),
    .pix_mult_in(bc_mult), .pix_shadowA_in(bc_sh), .pix_shadowB_in(bc_sh),
    .out_valid(c_ovalid), .out_ready(bc_oready), .sum_out(c_sum), .out_mode(c_omode),
    .overflow(c_ovf), .busy(c_busy));

  iterative_tree_reducer #(.SIDE(8), .DATA_W(8)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_valid), .in_ready(d_ready), .mode(d_mode),
    .pix_mult_in(d_mult), .pix_shadowA_in(d_sh), .pix_shadowB_in(d_sh),
    .out_valid(d_ovalid), .out_ready(d_oready), .sum_out(d_sum), .out_mode(d_omode),
    .overflow(d_ovf), .busy(d_busy));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame through A with out_ready held high: latency, result fields, handshake.
  task automatic a_frame(input string tag, input logic [1:0] m, input int exp_sum, input logic exp_ovf);
    int lat;
    @(negedge clk);
    a_mode = m; a_valid = 1'b1; a_oready = 1'b1;
    check_eq({tag, "_rdy"}, a_ready, 1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    lat = 0;
    while (!a_ovalid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check_eq({tag, "_lat"}, lat, 2);
    check_eq({tag, "_sum"}, a_sum, exp_sum);
    check_eq({tag, "_ovf"}, a_ovf, exp_ovf);
    check_eq({tag, "_mode"}, a_omode, m);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_vld_drop"}, a_ovalid, 0);
    check_eq({tag, "_rdy_back"}, a_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc_n, acc2_edge, n_res;
    logic stable, rdy_before;
    logic [31:0] res_sum [2];
    logic [31:0] res_mode [2];

    rst = 1'b0;
    a_valid = 1'b0; a_oready = 1'b0; a_mode = 2'd0;
    bc_valid = 1'b0; bc_oready = 1'b0; bc_mode = 2'd0;
    d_valid = 1'b0; d_oready = 1'b0; d_mode = 2'd0;
    foreach (a_mult[x, y]) begin a_mult[x][y] = 8'd0; a_shA[x][y] = 8'd0; a_shB[x][y] = 8'd0; end
    foreach (bc_mult[x, y]) begin bc_mult[x][y] = 8'd255; bc_sh[x][y] = 8'd0; end
    foreach (d_mult[x, y]) begin d_mult[x][y] = 8'd1; d_sh[x][y] = 8'd0; end
    #2 rst = 1'b1;
    #1;
    check_eq("rst_ready", a_ready, 0);
    check_eq("rst_valid", a_ovalid, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_sum", a_sum, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("rst_ready_low_at_release", a_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready_after_1cyc", a_ready, 1);

    // All ones, mode 0: 16 pixels
    foreach (a_mult[x, y]) a_mult[x][y] = 8'd1;
    a_frame("ones", 2'd0, 16, 1'b0);

    // shadowA = 4x+y (0..15), shadowB = 5: sum|v-5| = 15 + 0 + 55 = 70; plain shadowA = 120
    foreach (a_shA[x, y]) begin a_shA[x][y] = 8'(4 * x + y); a_shB[x][y] = 8'd5; end
    a_frame("absdiff", 2'd3, 70, 1'b0);
    a_frame("shadowA", 2'd1, 120, 1'b0);

    // 16 x 255 = 4080 fits the 12-bit accumulator exactly
    foreach (a_mult[x, y]) a_mult[x][y] = 8'd255;
    a_frame("max_no_ovf", 2'd0, 4080, 1'b0);

    // 8-bit accumulator, all 255: saturate -> 255; wrap -> 1020%256=252, 4*252%256=240
    @(negedge clk);
    bc_valid = 1'b1; bc_oready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bc_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("sat_not_yet", b_ovalid, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("sat_valid", b_ovalid, 1);
    check_eq("sat_sum", b_sum, 255);
    check_eq("sat_ovf", b_ovf, 1);
    check_eq("wrap_valid", c_ovalid, 1);
    check_eq("wrap_sum", c_sum, 240);
    check_eq("wrap_ovf", c_ovf, 1);

    // Back-pressure: shadowB = 7 in mode 2 -> 112, held for 10 cycles against a second in_valid
    foreach (a_shB[x, y]) a_shB[x][y] = 8'd7;
    @(negedge clk);
    a_mode = 2'd2; a_valid = 1'b1; a_oready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    lat = 0;
    while (!a_ovalid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check_eq("bp_lat", lat, 2);
    a_valid = 1'b1; a_mode = 2'd0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_sum !== 12'd112 || a_ovalid !== 1'b1 || a_ready !== 1'b0) stable = 1'b0;
    end
    check_eq("bp_stable", stable, 1);
    check_eq("bp_sum", a_sum, 112);
    check_eq("bp_mode", a_omode, 2);
    check_eq("bp_busy", a_busy, 1);
    a_valid = 1'b0; a_oready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_vld_drop", a_ovalid, 0);
    check_eq("bp_rdy_back", a_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_no_ghost_busy", a_busy, 0);

    // Back-to-back: ones (mode 0) then shadowA=3 (mode 1); mode swap during REDUCE is harmless
    foreach (a_mult[x, y]) begin a_mult[x][y] = 8'd1; a_shA[x][y] = 8'd3; end
    @(negedge clk);
    a_mode = 2'd0; a_valid = 1'b1; a_oready = 1'b1;
    check_eq("b2b_rdy", a_ready, 1);
    @(posedge clk);
    @(negedge clk);
    a_mode = 2'd1;
    acc_n = 1; acc2_edge = -1; n_res = 0;
    for (int i = 1; i <= 12; i++) begin
      rdy_before = a_ready & a_valid;
      @(posedge clk);
      if (rdy_before) begin acc_n++; acc2_edge = i; end
      @(negedge clk);
      if (acc_n == 2) a_valid = 1'b0;
      if (a_ovalid) begin
        if (n_res < 2) begin res_sum[n_res] = 32'(a_sum); res_mode[n_res] = 32'(a_omode); end
        n_res++;
      end
    end
    check_eq("b2b_accept2_edge", acc2_edge, 4);
    check_eq("b2b_nres", n_res, 2);
    if (n_res >= 2) begin
      check_eq("b2b_sum0", res_sum[0], 16);
      check_eq("b2b_mode0", res_mode[0], 0);
      check_eq("b2b_sum1", res_sum[1], 48);
      check_eq("b2b_mode1", res_mode[1], 1);
    end else begin
      check_eq("b2b_results_present", n_res, 2);
    end

    // Reset in the cycle after accept on the 8x8 instance, then a frame of 2s -> 128
    @(negedge clk);
    d_valid = 1'b1; d_oready = 1'b1; d_mode = 2'd0;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    check_eq("d_busy_pre_rst", d_busy, 1);
    rst = 1'b1;
    #1;
    check_eq("d_rst_valid", d_ovalid, 0);
    check_eq("d_rst_sum", d_sum, 0);
    check_eq("d_rst_busy", d_busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("d_rdy_after_rst", d_ready, 1);
    foreach (d_mult[x, y]) d_mult[x][y] = 8'd2;
    d_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    lat = 0;
    while (!d_ovalid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check_eq("d_lat", lat, 3);
    check_eq("d_sum", d_sum, 128);
    check_eq("d_ovf", d_ovf, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("d_rdy_back", d_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
